// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one pipelined floating-point core among NUM_REQ requesters.
// An owner-tag FIFO routes the core's in-order results back to the requester that issued each op.
module fp_unit_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 32,
  parameter int TAG_DEPTH = 16,
  parameter int PTR_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        hold,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_a,
  input  logic [NUM_REQ*DATA_W-1:0]   req_b,
  output logic [NUM_REQ-1:0]          req_grant,
  output logic [DATA_W-1:0]           core_a,
  output logic [DATA_W-1:0]           core_b,
  output logic                        core_nd,
  input  logic                        core_rfd,
  input  logic [DATA_W-1:0]           core_result,
  input  logic                        core_rdy,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [PTR_W:0]              in_flight,
  output logic                        err_orphan
);

  localparam int SEL_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(TAG_DEPTH);

  logic [SEL_W-1:0]     rr_ptr;
  logic [SEL_W-1:0]     sel;
  logic [SEL_W-1:0]     sel_next;
  logic [SEL_W-1:0]     head_tag;
  logic [SEL_W:0]       sum;
  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   rot;
  logic [NUM_REQ-1:0]   sel_onehot;
  logic [NUM_REQ-1:0]   head_onehot;
  logic [2*NUM_REQ-1:0] dbl;
  logic [DATA_W-1:0]    sel_a;
  logic [DATA_W-1:0]    sel_b;
  logic                 found;
  logic                 issue;
  logic                 pop;
  logic [SEL_W-1:0]     tags [TAG_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;

  // The requester granted last edge is masked so a stale req_valid cannot issue twice.
  always_comb begin
    eligible = req_valid & ~req_grant;
    dbl      = {eligible, eligible} >> rr_ptr;
    rot      = dbl[NUM_REQ-1:0];
    found    = 1'b0;
    sum      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (SEL_W+1)'(k);
      end
    end
    if (sum >= (SEL_W+1)'(NUM_REQ)) sum = sum - (SEL_W+1)'(NUM_REQ);
    sel      = sum[SEL_W-1:0];
    sel_next = (sel == SEL_W'(NUM_REQ-1)) ? '0 : sel + 1'b1;
  end

  always_comb begin
    sel_a       = '0;
    sel_b       = '0;
    sel_onehot  = '0;
    head_onehot = '0;
    head_tag    = tags[rd_ptr];
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_onehot[k]  = (sel == SEL_W'(k));
      head_onehot[k] = (head_tag == SEL_W'(k));
      if (sel_onehot[k]) begin
        sel_a = req_a[k*DATA_W +: DATA_W];
        sel_b = req_b[k*DATA_W +: DATA_W];
      end
    end
  end

  // Full uses the current count, so a same-cycle pop never frees a slot early.
  assign issue = found && core_rfd && !hold && (in_flight != FULL_CNT);
  assign pop   = core_rdy && (in_flight != '0);

  // Tag storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (issue) tags[wr_ptr] <= sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_grant  <= '0;
      core_a     <= '0;
      core_b     <= '0;
      core_nd    <= 1'b0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      in_flight  <= '0;
      err_orphan <= 1'b0;
      rr_ptr     <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      core_nd   <= issue;
      req_grant <= issue ? sel_onehot : '0;
      rsp_valid <= pop ? head_onehot : '0;
      if (issue) begin
        core_a <= sel_a;
        core_b <= sel_b;
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= sel_next;
      end
      if (pop) begin
        rsp_data <= core_result;
        rd_ptr   <= rd_ptr + 1'b1;
      end
      if (core_rdy && (in_flight == '0)) err_orphan <= 1'b1;
      case ({issue, pop})
        2'b10:   in_flight <= in_flight + (PTR_W+1)'(1);
        2'b01:   in_flight <= in_flight - (PTR_W+1)'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Self-checking bench for fp_unit_arbiter: requester and pipelined-core models, a response
// scoreboard, a table of arbitration vectors and hand-written multi-cycle corner cases.
module tb_fp_unit_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int D   = 16;
  localparam int PW  = 4;
  localparam int LAT = 3;

  logic           clk;
  logic           rst;
  logic           hold;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_grant;
  logic [W-1:0]   core_a;
  logic [W-1:0]   core_b;
  logic           core_nd;
  logic           core_rfd;
  logic [W-1:0]   core_result;
  logic           core_rdy;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_data;
  logic [PW:0]    in_flight;
  logic           err_orphan;

  fp_unit_arbiter #(.NUM_REQ(N), .DATA_W(W), .TAG_DEPTH(D), .PTR_W(PW)) dut (
    .clk(clk), .rst(rst), .hold(hold), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_grant(req_grant), .core_a(core_a), .core_b(core_b), .core_nd(core_nd),
    .core_rfd(core_rfd), .core_result(core_result), .core_rdy(core_rdy),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .in_flight(in_flight), .err_orphan(err_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int idx; logic [W-1:0] data; } sb_t;
  typedef struct { logic [W-1:0] data; int t; } cq_t;
  typedef struct { logic [N-1:0] valid; logic hold; logic rfd; logic [N-1:0] grant; } vec_t;

  sb_t          sb[$];
  cq_t          cq[$];
  logic [W-1:0] a_op [N];
  logic [W-1:0] b_op [N];
  logic         sticky;
  logic         core_auto;
  logic         rdy_en;
  int           checks;
  int           failures;
  int           cyc;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = a_op[i];
      req_b[i*W +: W] = b_op[i];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe outputs at the falling edge, update models, drive the core's return.
  task automatic step();
    sb_t e;
    logic exp_rsp;
    @(negedge clk);
    cyc++;
    exp_rsp = core_rdy && (sb.size() > 0);
    chk("rsp_present", rsp_valid != '0, exp_rsp);
    if (rsp_valid != '0) begin
      if (sb.size() == 0) chk("rsp_unexpected", rsp_valid, 0);
      else begin
        e = sb.pop_front();
        chk("rsp_owner", rsp_valid, 64'(1) << e.idx);
        chk("rsp_data", rsp_data, e.data);
      end
    end
    chk("grant_onehot0", $onehot0(req_grant), 1);
    chk("core_nd", core_nd, req_grant != '0);
    for (int i = 0; i < N; i++) begin
      if (req_grant[i]) begin
        chk("core_a", core_a, a_op[i]);
        chk("core_b", core_b, b_op[i]);
        sb.push_back('{i, a_op[i] + b_op[i]});
        if (!sticky) begin
          a_op[i] = $urandom;
          b_op[i] = $urandom;
        end
      end
    end
    if (core_nd) cq.push_back('{core_a + core_b, cyc + LAT});
    chk("in_flight", in_flight, sb.size());
    if (core_auto) begin
      if (rdy_en && cq.size() > 0 && cq[0].t <= cyc) begin
        core_rdy    = 1'b1;
        core_result = cq[0].data;
        void'(cq.pop_front());
      end else begin
        core_rdy = 1'b0;
      end
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = '0; hold = 1'b0; core_rfd = 1'b1; core_rdy = 1'b0; core_result = '0;
    sticky = 1'b0; core_auto = 1'b1; rdy_en = 1'b1;
    sb.delete(); cq.delete();
    for (int i = 0; i < N; i++) begin
      a_op[i] = $urandom;
      b_op[i] = $urandom;
    end
    @(negedge clk);
    chk("rst_grant", req_grant, 0);
    chk("rst_core_a", core_a, 0);
    chk("rst_core_b", core_b, 0);
    chk("rst_core_nd", core_nd, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_in_flight", in_flight, 0);
    chk("rst_err_orphan", err_orphan, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && (in_flight != '0 || cq.size() != 0); k++) step();
    chk("drain_in_flight", in_flight, 0);
    chk("drain_scoreboard", sb.size(), 0);
  endtask

  vec_t vt [15];
  int   gcount;
  int   consec;
  logic prev_g;

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin a_op[i] = '0; b_op[i] = '0; end
    vt[0]  = '{4'b1111, 1'b0, 1'b1, 4'b0001};
    vt[1]  = '{4'b1111, 1'b0, 1'b1, 4'b0010};
    vt[2]  = '{4'b1111, 1'b0, 1'b1, 4'b0100};
    vt[3]  = '{4'b1111, 1'b0, 1'b1, 4'b1000};
    vt[4]  = '{4'b1111, 1'b0, 1'b1, 4'b0001};
    vt[5]  = '{4'b1111, 1'b1, 1'b1, 4'b0000};
    vt[6]  = '{4'b1111, 1'b1, 1'b1, 4'b0000};
    vt[7]  = '{4'b1111, 1'b0, 1'b0, 4'b0000};
    vt[8]  = '{4'b1111, 1'b0, 1'b1, 4'b0010};
    vt[9]  = '{4'b1001, 1'b0, 1'b1, 4'b1000};
    vt[10] = '{4'b1001, 1'b0, 1'b1, 4'b0001};
    vt[11] = '{4'b0100, 1'b0, 1'b1, 4'b0100};
    vt[12] = '{4'b0100, 1'b0, 1'b1, 4'b0000};
    vt[13] = '{4'b0100, 1'b0, 1'b1, 4'b0100};
    vt[14] = '{4'b0000, 1'b0, 1'b1, 4'b0000};

    // single op from reset
    reset_dut();
    a_op[0] = 32'h3F800000; b_op[0] = 32'h40000000;
    req_valid = 4'b0001;
    step();
    chk("t1_grant", req_grant, 4'b0001);
    chk("t1_core_nd", core_nd, 1);
    req_valid = '0;
    for (int k = 0; k < 20 && rsp_valid == '0; k++) step();
    chk("t1_rsp_valid", rsp_valid, 4'b0001);
    chk("t1_rsp_data", rsp_data, 32'h7F800000);
    drain();

    // round robin, hold and rfd back-pressure, mask behaviour
    reset_dut();
    for (int i = 0; i < 15; i++) begin
      req_valid = vt[i].valid;
      hold      = vt[i].hold;
      core_rfd  = vt[i].rfd;
      step();
      chk($sformatf("vec%0d_grant", i), req_grant, vt[i].grant);
    end
    hold = 1'b0; core_rfd = 1'b1; req_valid = '0;
    drain();

    // single stale requester: grants only on alternate edges
    reset_dut();
    sticky = 1'b1;
    req_valid = 4'b0100;
    gcount = 0; consec = 0; prev_g = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (req_grant[2]) begin
        gcount++;
        if (prev_g) consec++;
      end
      prev_g = req_grant[2];
    end
    chk("t3_grant_count", gcount, 6);
    chk("t3_consecutive", consec, 0);
    req_valid = '0;
    sticky = 1'b0;
    drain();

    // tag FIFO full with core results withheld, then resume and drain
    reset_dut();
    rdy_en = 1'b0;
    req_valid = 4'b1111;
    gcount = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (req_grant != '0) gcount++;
    end
    chk("t4_grants_to_full", gcount, 16);
    chk("t4_in_flight_full", in_flight, 16);
    chk("t4_no_grant_full", req_grant, 0);
    rdy_en = 1'b1;
    gcount = 0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (req_grant != '0) gcount++;
    end
    chk("t4_resumed", gcount > 0, 1);
    req_valid = '0;
    drain();

    // orphan result, then asynchronous reset mid-stream
    core_auto = 1'b0;
    core_rdy = 1'b1;
    core_result = 32'hDEADBEEF;
    step();
    chk("t6_err_orphan", err_orphan, 1);
    chk("t6_rsp_valid", rsp_valid, 0);
    core_rdy = 1'b0;
    step();
    chk("t6_err_sticky", err_orphan, 1);
    core_auto = 1'b1;
    req_valid = 4'b0011;
    step(); step(); step();
    chk("t6_busy_before_rst", in_flight != '0, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_err", err_orphan, 0);
    chk("t6_rst_in_flight", in_flight, 0);
    chk("t6_rst_grant", req_grant, 0);
    chk("t6_rst_core_nd", core_nd, 0);
    chk("t6_rst_rsp_valid", rsp_valid, 0);
    sb.delete(); cq.delete();
    core_rdy = 1'b0; req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    req_valid = 4'b0001;
    step();
    chk("t6_post_rst_grant", req_grant, 4'b0001);
    req_valid = '0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
